// File: rtl/draw_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : draw_sequencer
// Description : Runs the screen-fill engine and then the circle engine on each
//               start request. Muxes the active engine's pixel stream onto
//               the single VGA plot port, drops off-screen pixels and counts
//               how many were dropped.
// Revision    : 1.0 - initial release
// ============================================================================
module draw_sequencer #(
    parameter int          SCREEN_W     = 160,
    parameter int          SCREEN_H     = 120,
    parameter logic [2:0]  CLEAR_COLOUR = 3'b000,
    parameter int          CLEAR_EN     = 1,
    parameter int          TIMEOUT      = 65535
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  colour,
    input  logic [7:0]  centre_x,
    input  logic [6:0]  centre_y,
    input  logic [7:0]  radius,
    output logic        done,
    output logic        error,
    output logic [15:0] clip_count,
    output logic        fill_start,
    output logic [2:0]  fill_colour,
    input  logic        fill_done,
    input  logic [7:0]  fill_x,
    input  logic [6:0]  fill_y,
    input  logic        fill_plot,
    output logic        circ_start,
    output logic [2:0]  circ_colour,
    output logic [7:0]  circ_centre_x,
    output logic [6:0]  circ_centre_y,
    output logic [7:0]  circ_radius,
    input  logic        circ_done,
    input  logic [7:0]  circ_x,
    input  logic [6:0]  circ_y,
    input  logic        circ_plot,
    output logic [7:0]  vga_x,
    output logic [6:0]  vga_y,
    output logic [2:0]  vga_colour,
    output logic        vga_plot
);

    localparam logic [2:0]  S_IDLE     = 3'd0;
    localparam logic [2:0]  S_FILL     = 3'd1;
    localparam logic [2:0]  S_FILL_REL = 3'd2;
    localparam logic [2:0]  S_CIRC     = 3'd3;
    localparam logic [2:0]  S_CIRC_REL = 3'd4;
    localparam logic [2:0]  S_DONE     = 3'd5;

    // One extra bit so a full-range screen size still compares correctly
    localparam logic [8:0]  c_SCREEN_W = 9'(SCREEN_W);
    localparam logic [7:0]  c_SCREEN_H = 8'(SCREEN_H);
    // Counter value seen on the TIMEOUT-th cycle of a phase
    localparam logic [15:0] c_TLIM     = 16'(TIMEOUT - 1);

    logic [2:0]  r_state;
    logic [15:0] r_tcnt;
    logic        r_done;
    logic        r_error;
    logic [15:0] r_clip_count;
    logic        r_fill_start;
    logic        r_circ_start;
    logic [2:0]  r_circ_colour;
    logic [7:0]  r_circ_centre_x;
    logic [6:0]  r_circ_centre_y;
    logic [7:0]  r_circ_radius;
    logic [7:0]  r_vga_x;
    logic [6:0]  r_vga_y;
    logic [2:0]  r_vga_colour;
    logic        r_vga_plot;

    logic        w_in_fill;
    logic        w_in_circ;
    logic [7:0]  w_sel_x;
    logic [6:0]  w_sel_y;
    logic        w_sel_plot;
    logic        w_offscreen;
    logic        w_clip;
    logic        w_tmo;

    // Select the active engine's pixel and classify it as on/off screen
    always_comb begin
        w_in_fill   = (r_state == S_FILL);
        w_in_circ   = (r_state == S_CIRC);
        w_sel_x     = w_in_fill ? fill_x : circ_x;
        w_sel_y     = w_in_fill ? fill_y : circ_y;
        w_sel_plot  = (w_in_fill & fill_plot) | (w_in_circ & circ_plot);
        w_offscreen = ({1'b0, w_sel_x} >= c_SCREEN_W) || ({1'b0, w_sel_y} >= c_SCREEN_H);
        w_clip      = w_sel_plot & w_offscreen;
        w_tmo       = (r_tcnt == c_TLIM);
    end

    // Sequencing FSM: engine handshakes, timeout abort and parameter latch
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_tcnt          <= 16'd0;
            r_done          <= 1'b0;
            r_error         <= 1'b0;
            r_fill_start    <= 1'b0;
            r_circ_start    <= 1'b0;
            r_circ_colour   <= 3'd0;
            r_circ_centre_x <= 8'd0;
            r_circ_centre_y <= 7'd0;
            r_circ_radius   <= 8'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_circ_colour   <= colour;
                        r_circ_centre_x <= centre_x;
                        r_circ_centre_y <= centre_y;
                        r_circ_radius   <= radius;
                        r_error         <= 1'b0;
                        r_tcnt          <= 16'd0;
                        if (CLEAR_EN != 0) begin
                            r_state      <= S_FILL;
                            r_fill_start <= 1'b1;
                        end else begin
                            r_state      <= S_CIRC;
                            r_circ_start <= 1'b1;
                        end
                    end
                end
                S_FILL: begin
                    // done is checked first so a same-cycle done beats the abort
                    if (fill_done) begin
                        r_state      <= S_FILL_REL;
                        r_fill_start <= 1'b0;
                    end else if (w_tmo) begin
                        r_state      <= S_DONE;
                        r_fill_start <= 1'b0;
                        r_done       <= 1'b1;
                        r_error      <= 1'b1;
                    end else begin
                        r_tcnt <= r_tcnt + 16'd1;
                    end
                end
                S_FILL_REL: begin
                    r_state      <= S_CIRC;
                    r_circ_start <= 1'b1;
                    r_tcnt       <= 16'd0;
                end
                S_CIRC: begin
                    if (circ_done) begin
                        r_state      <= S_CIRC_REL;
                        r_circ_start <= 1'b0;
                    end else if (w_tmo) begin
                        r_state      <= S_DONE;
                        r_circ_start <= 1'b0;
                        r_done       <= 1'b1;
                        r_error      <= 1'b1;
                    end else begin
                        r_tcnt <= r_tcnt + 16'd1;
                    end
                end
                S_CIRC_REL: begin
                    r_state <= S_DONE;
                    r_done  <= 1'b1;
                end
                S_DONE: begin
                    // No auto-restart: start must drop before a new run
                    if (!start) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_fill_start <= 1'b0;
                    r_circ_start <= 1'b0;
                    r_done       <= 1'b0;
                end
            endcase
        end
    end

    // Registered pixel port and saturating clip counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vga_x      <= 8'd0;
            r_vga_y      <= 7'd0;
            r_vga_colour <= 3'd0;
            r_vga_plot   <= 1'b0;
            r_clip_count <= 16'd0;
        end else begin
            if ((r_state == S_IDLE) && start) begin
                r_clip_count <= 16'd0;
            end else if (w_clip && (r_clip_count != 16'hFFFF)) begin
                r_clip_count <= r_clip_count + 16'd1;
            end

            if (w_in_fill || w_in_circ) begin
                r_vga_x      <= w_sel_x;
                r_vga_y      <= w_sel_y;
                r_vga_colour <= w_in_fill ? CLEAR_COLOUR : r_circ_colour;
                r_vga_plot   <= w_sel_plot & ~w_offscreen;
            end else begin
                r_vga_plot   <= 1'b0;
            end
        end
    end

    assign done          = r_done;
    assign error         = r_error;
    assign clip_count    = r_clip_count;
    assign fill_start    = r_fill_start;
    assign fill_colour   = CLEAR_COLOUR;
    assign circ_start    = r_circ_start;
    assign circ_colour   = r_circ_colour;
    assign circ_centre_x = r_circ_centre_x;
    assign circ_centre_y = r_circ_centre_y;
    assign circ_radius   = r_circ_radius;
    assign vga_x         = r_vga_x;
    assign vga_y         = r_vga_y;
    assign vga_colour    = r_vga_colour;
    assign vga_plot      = r_vga_plot;

endmodule
`default_nettype wire

// File: tb/tb_draw_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_draw_sequencer
// Description : Self-checking bench for draw_sequencer. A default instance
//               covers the fill+circle flow, clipping and reset; a second
//               instance (no fill phase, short timeout) covers aborts.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_draw_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  colour;
    logic [7:0]  centre_x;
    logic [6:0]  centre_y;
    logic [7:0]  radius;
    logic        fill_done, fill_plot, circ_done, circ_plot;
    logic [7:0]  fill_x, circ_x;
    logic [6:0]  fill_y, circ_y;

    // Default instance outputs
    logic        done, error, fill_start, circ_start, vga_plot;
    logic [15:0] clip_count;
    logic [2:0]  fill_colour, circ_colour, vga_colour;
    logic [7:0]  circ_centre_x, circ_radius, vga_x;
    logic [6:0]  circ_centre_y, vga_y;

    // Alternate instance outputs
    logic        b_done, b_error, b_fill_start, b_circ_start, b_vga_plot;
    logic [15:0] b_clip_count;
    logic [2:0]  b_fill_colour, b_circ_colour, b_vga_colour;
    logic [7:0]  b_circ_centre_x, b_circ_radius, b_vga_x;
    logic [6:0]  b_circ_centre_y, b_vga_y;

    draw_sequencer u_dut (
        .clk(clk), .rst(rst), .start(start), .colour(colour),
        .centre_x(centre_x), .centre_y(centre_y), .radius(radius),
        .done(done), .error(error), .clip_count(clip_count),
        .fill_start(fill_start), .fill_colour(fill_colour), .fill_done(fill_done),
        .fill_x(fill_x), .fill_y(fill_y), .fill_plot(fill_plot),
        .circ_start(circ_start), .circ_colour(circ_colour),
        .circ_centre_x(circ_centre_x), .circ_centre_y(circ_centre_y),
        .circ_radius(circ_radius), .circ_done(circ_done),
        .circ_x(circ_x), .circ_y(circ_y), .circ_plot(circ_plot),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot)
    );

    draw_sequencer #(.CLEAR_EN(0), .TIMEOUT(100)) u_alt (
        .clk(clk), .rst(rst), .start(start), .colour(colour),
        .centre_x(centre_x), .centre_y(centre_y), .radius(radius),
        .done(b_done), .error(b_error), .clip_count(b_clip_count),
        .fill_start(b_fill_start), .fill_colour(b_fill_colour), .fill_done(fill_done),
        .fill_x(fill_x), .fill_y(fill_y), .fill_plot(fill_plot),
        .circ_start(b_circ_start), .circ_colour(b_circ_colour),
        .circ_centre_x(b_circ_centre_x), .circ_centre_y(b_circ_centre_y),
        .circ_radius(b_circ_radius), .circ_done(circ_done),
        .circ_x(circ_x), .circ_y(circ_y), .circ_plot(circ_plot),
        .vga_x(b_vga_x), .vga_y(b_vga_y), .vga_colour(b_vga_colour), .vga_plot(b_vga_plot)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference state: dropped-pixel count and the colour the run latched
    int         exp_clip;
    logic [2:0] exp_col;

    typedef struct {
        logic [7:0] x;
        logic [6:0] y;
        logic       plot;
        logic       exp_plot;
    } clip_vec_t;
    clip_vec_t tbl[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic on_screen(input logic [7:0] x, input logic [6:0] y);
        return (int'(x) < 160) && (int'(y) < 120);
    endfunction

    // One cycle on the default instance. src: 0 = no engine active,
    // 1 = fill phase, 2 = circle phase. The inactive engine gets random
    // traffic (including done) which must be ignored.
    task automatic drive(input int src, input logic [7:0] x, input logic [6:0] y,
                         input logic plot, input logic dn);
        logic exp_plot;
        fill_x = 8'($urandom); fill_y = 7'($urandom);
        fill_plot = 1'($urandom); fill_done = 1'($urandom);
        circ_x = 8'($urandom); circ_y = 7'($urandom);
        circ_plot = 1'($urandom); circ_done = 1'($urandom);
        if (src == 1) begin
            fill_x = x; fill_y = y; fill_plot = plot; fill_done = dn;
        end else if (src == 2) begin
            circ_x = x; circ_y = y; circ_plot = plot; circ_done = dn;
        end
        step();
        if (src == 0) begin
            check("plot_idle", 32'(vga_plot), 32'd0);
        end else begin
            exp_plot = plot && on_screen(x, y);
            if (plot && !on_screen(x, y) && exp_clip < 65535) exp_clip++;
            if (plot)
                check("pix", {13'd0, vga_plot, vga_x, vga_y, vga_colour},
                      {13'd0, exp_plot, x, y, (src == 1) ? 3'b000 : exp_col});
            else
                check("no_plot", 32'(vga_plot), 32'd0);
        end
    endtask

    // Full start -> fill -> circle -> done run on the default instance
    task automatic run_seq(input int n_fill, input int n_circ, input int cx, input int cy,
                           input int r, input logic [2:0] col, input bit use_table);
        int dx, dy;
        colour = col; centre_x = 8'(cx); centre_y = 7'(cy); radius = 8'(r);
        start = 1'b1;
        exp_clip = 0;
        exp_col = col;
        drive(0, 8'd0, 7'd0, 1'b0, 1'b0);
        check("fill_go", {29'd0, fill_start, circ_start, done}, 32'b100);
        check("latch", 32'({circ_colour, circ_centre_x, circ_centre_y, circ_radius}),
              32'({col, 8'(cx), 7'(cy), 8'(r)}));
        // Latched parameters must not follow later input changes
        colour = 3'($urandom); centre_x = 8'($urandom);
        centre_y = 7'($urandom); radius = 8'($urandom);

        for (int i = 0; i < n_fill; i++) begin
            while ($urandom_range(0, 7) == 0) drive(1, 8'($urandom), 7'($urandom), 1'b0, 1'b0);
            if (i == n_fill - 1) check("fill_hold", 32'(fill_start), 32'd1);
            drive(1, 8'(i % 160), 7'(i / 160), 1'b1, (i == n_fill - 1));
        end
        check("fill_rel", {29'd0, fill_start, circ_start, done}, 32'd0);
        drive(0, 8'd0, 7'd0, 1'b0, 1'b0);
        check("circ_go", {30'd0, fill_start, circ_start}, 32'b01);
        radius = 8'($urandom);

        if (use_table) begin
            for (int k = 0; k < 9; k++) begin
                drive(2, tbl[k].x, tbl[k].y, tbl[k].plot, 1'b0);
                check("clip_tbl", 32'(vga_plot), 32'(tbl[k].exp_plot));
            end
        end
        for (int j = 0; j < n_circ; j++) begin
            while ($urandom_range(0, 7) == 0) drive(2, 8'($urandom), 7'($urandom), 1'b0, 1'b0);
            dx = int'($urandom_range(0, 2 * r)) - r;
            dy = int'($urandom_range(0, 2 * r)) - r;
            drive(2, 8'(cx + dx), 7'(cy + dy), 1'b1, (j == n_circ - 1));
        end
        check("circ_rel", {30'd0, circ_start, done}, 32'd0);
        drive(0, 8'd0, 7'd0, 1'b0, 1'b0);
        check("done", {30'd0, done, error}, 32'b10);
        check("clip_count", 32'(clip_count), 32'(exp_clip));
        check("circ_hold", 32'({circ_colour, circ_centre_x, circ_centre_y, circ_radius}),
              32'({col, 8'(cx), 7'(cy), 8'(r)}));
    endtask

    // Hold start in DONE (no restart allowed), then release to IDLE
    task automatic finish_seq();
        for (int i = 0; i < 10; i++) begin
            radius = 8'($urandom);
            drive(0, 8'd0, 7'd0, 1'b0, 1'b0);
            check("done_hold", {29'd0, done, fill_start, circ_start}, 32'b100);
        end
        start = 1'b0;
        drive(0, 8'd0, 7'd0, 1'b0, 1'b0);
        check("idle_ret", 32'(done), 32'd0);
        drive(0, 8'd0, 7'd0, 1'b0, 1'b0);
        check("no_restart", 32'({fill_start, circ_start}), 32'd0);
    endtask

    initial begin
        tbl[0] = '{x: 8'd159, y: 7'd119, plot: 1'b1, exp_plot: 1'b1};
        tbl[1] = '{x: 8'd160, y: 7'd0,   plot: 1'b1, exp_plot: 1'b0};
        tbl[2] = '{x: 8'd0,   y: 7'd120, plot: 1'b1, exp_plot: 1'b0};
        tbl[3] = '{x: 8'd241, y: 7'd10,  plot: 1'b1, exp_plot: 1'b0};
        tbl[4] = '{x: 8'd10,  y: 7'd125, plot: 1'b1, exp_plot: 1'b0};
        tbl[5] = '{x: 8'd255, y: 7'd127, plot: 1'b1, exp_plot: 1'b0};
        tbl[6] = '{x: 8'd0,   y: 7'd0,   plot: 1'b1, exp_plot: 1'b1};
        tbl[7] = '{x: 8'd200, y: 7'd50,  plot: 1'b0, exp_plot: 1'b0};
        tbl[8] = '{x: 8'd25,  y: 7'd3,   plot: 1'b1, exp_plot: 1'b1};

        rst = 1'b1; start = 1'b0;
        colour = 3'd5; centre_x = 8'd33; centre_y = 7'd22; radius = 8'd9;
        fill_done = 1'b0; fill_plot = 1'b0; fill_x = 8'd0; fill_y = 7'd0;
        circ_done = 1'b0; circ_plot = 1'b0; circ_x = 8'd0; circ_y = 7'd0;
        exp_clip = 0; exp_col = 3'd0;
        step(); step();

        // Reset values
        check("rst_ctrl", {27'd0, done, error, fill_start, circ_start, vga_plot}, 32'd0);
        check("rst_pix", 32'({vga_x, vga_y, vga_colour}), 32'd0);
        check("rst_clip", 32'(clip_count), 32'd0);
        check("rst_latch", 32'({circ_colour, circ_centre_x, circ_centre_y, circ_radius}), 32'd0);
        check("rst_alt", {28'd0, b_done, b_error, b_fill_start, b_circ_start}, 32'd0);
        check("fill_colour", 32'(fill_colour), 32'd0);
        rst = 1'b0;
        step();

        // Nominal: full-screen clear then a fully on-screen circle
        run_seq(19200, 160, 80, 60, 20, 3'b011, 1'b0);
        finish_seq();

        // Clipping: circle near the corner wraps off-screen
        run_seq(40, 80, 5, 5, 20, 3'($urandom), 1'b1);
        finish_seq();

        // Reset 500 cycles into the fill phase
        start = 1'b1;
        exp_clip = 0;
        drive(0, 8'd0, 7'd0, 1'b0, 1'b0);
        for (int i = 0; i < 500; i++)
            drive(1, 8'($urandom), 7'($urandom), 1'($urandom), 1'b0);
        check("clip_pre_rst", 32'(clip_count), 32'(exp_clip));
        rst = 1'b1; start = 1'b0;
        drive(0, 8'd0, 7'd0, 1'b0, 1'b0);
        check("rst_mid", {27'd0, fill_start, circ_start, done, error, vga_plot}, 32'd0);
        check("rst_mid_clip", 32'(clip_count), 32'd0);
        rst = 1'b0;
        drive(0, 8'd0, 7'd0, 1'b0, 1'b0);
        check("rst_idle", 32'({fill_start, circ_start, done}), 32'd0);
        run_seq(100, 30, 70, 50, 10, 3'($urandom), 1'b0);
        finish_seq();

        // No-fill instance: circle timeout after 100 cycles
        rst = 1'b1; start = 1'b0;
        step();
        rst = 1'b0;
        circ_plot = 1'b0; circ_done = 1'b0; fill_done = 1'b0; fill_plot = 1'b0;
        step();
        check("alt_idle", 32'({b_circ_start, b_fill_start}), 32'd0);
        start = 1'b1;
        step();
        check("alt_circ_go", 32'({b_circ_start, b_fill_start, b_done}), 32'b100);
        for (int i = 1; i < 100; i++) begin
            fill_plot = 1'($urandom);
            fill_x = 8'($urandom_range(0, 159));
            fill_y = 7'($urandom_range(0, 119));
            fill_done = 1'($urandom);
            step();
            check("alt_run", 32'({b_circ_start, b_fill_start, b_vga_plot, b_done}), 32'b1000);
        end
        step();
        check("alt_tmo", 32'({b_circ_start, b_fill_start, b_done, b_error}), 32'b0011);
        start = 1'b0;
        step();
        check("alt_idle_ret", 32'(b_done), 32'd0);

        // Done arriving on the timeout cycle wins
        start = 1'b1;
        step();
        for (int i = 1; i < 100; i++) step();
        circ_done = 1'b1;
        step();
        check("alt_race", 32'({b_circ_start, b_done, b_error}), 32'd0);
        circ_done = 1'b0;
        step();
        check("alt_race_done", 32'({b_done, b_error}), 32'b10);
        start = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/draw_sequencer.md
Name: draw_sequencer

Overview:
- Top-level controller for the VGA pixel port.
- On `start` it runs two engines in sequence: first the screen-fill engine clears the screen, then the circle engine draws one circle.
- It owns the single VGA plot interface. It muxes the active engine's pixel stream onto that interface, clips off-screen pixels, and counts how many it dropped.
- It sits between the top-level switch/key logic and the fill/circle engines.

Parameters:
- SCREEN_W, 160, visible width; x >= SCREEN_W is clipped.
- SCREEN_H, 120, visible height; y >= SCREEN_H is clipped.
- CLEAR_COLOUR, 3'b000, colour driven to the fill engine.
- CLEAR_EN, 1, when 0 the FILL phase is skipped.
- TIMEOUT, 65535, maximum cycles per engine phase before abort.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  level request; held high until done
- colour  in  3  circle colour
- centre_x  in  8  circle centre x
- centre_y  in  7  circle centre y
- radius  in  8  circle radius
- done  out  1  sequence complete (or aborted)
- error  out  1  set with done if a phase timed out
- clip_count  out  16  pixels dropped by clipping, saturating
- fill_start  out  1  fill engine start
- fill_colour  out  3  fill colour (= CLEAR_COLOUR)
- fill_done  in  1  fill engine done
- fill_x  in  8  fill engine pixel x
- fill_y  in  7  fill engine pixel y
- fill_plot  in  1  fill engine pixel valid
- circ_start  out  1  circle engine start
- circ_colour  out  3  latched colour
- circ_centre_x  out  8  latched centre_x
- circ_centre_y  out  7  latched centre_y
- circ_radius  out  8  latched radius
- circ_done  in  1  circle engine done
- circ_x  in  8  circle pixel x
- circ_y  in  7  circle pixel y
- circ_plot  in  1  circle pixel valid
- vga_x  out  8  registered pixel x
- vga_y  out  7  registered pixel y
- vga_colour  out  3  registered pixel colour
- vga_plot  out  1  registered pixel write strobe

Behaviour:
- Reset and clock:
  - Single clock domain; every register resets synchronously when rst=1 at posedge clk.
  - Reset values:
    - state=IDLE
    - done=0, error=0
    - fill_start=0, circ_start=0
    - vga_x=0, vga_y=0, vga_colour=0, vga_plot=0
    - latched circle parameters=0
    - clip_count=0
    - timeout counter=0
  - rst during any phase aborts immediately and drops both engine starts the same edge.
- Engine handshake:
  - The engine start is held high until the engine's done is sampled high.
  - The start is then driven low for at least one cycle (release state) before anything else proceeds.
  - Engine done is a level signal and is ignored outside its own phase.
- States:
  - IDLE: done=0. When start=1, latch colour/centre_x/centre_y/radius, clear error and clip_count, and go to FILL (CLEAR_EN=1) or CIRC (CLEAR_EN=0).
  - FILL: fill_start=1, mux source = fill. On fill_done=1 go to FILL_REL. On timeout go to DONE with error=1.
  - FILL_REL: fill_start=0, no source. Stays exactly 1 cycle, then goes to CIRC.
  - CIRC: circ_start=1, mux source = circle. On circ_done=1 go to CIRC_REL. On timeout go to DONE with error=1.
  - CIRC_REL: circ_start=0, 1 cycle, then goes to DONE.
  - DONE: done=1 (error held). When start=0 go to IDLE. While start stays 1, remain in DONE; there is no auto-restart.
- Timeout counter:
  - Clears on entry to FILL and to CIRC, and increments each cycle in those states.
  - Abort occurs when the count reaches TIMEOUT and the engine's done has not been seen.
  - If done and timeout occur on the same cycle, done wins (no error).
- Pixel mux:
  - vga_* are registered, with 1-cycle latency from the selected engine's x/y/plot.
  - vga_colour = CLEAR_COLOUR during FILL and the latched colour during CIRC.
  - Outside FILL/CIRC, vga_plot=0 next cycle.
  - A non-selected engine's plot is ignored.
- Clipping:
  - Applies when the selected engine's plot=1 and (x >= SCREEN_W or y >= SCREEN_H). This covers circle engine wrap-around, e.g. x=centre_x-offset underflowing to 255.
  - A clipped pixel gives vga_plot=0 next cycle, with vga_x/vga_y still updated.
  - Each clipped pixel increments clip_count by 1, saturating at 16'hFFFF.
- Parameter stability: circ_* outputs are held constant from IDLE exit until the next IDLE exit, regardless of input changes.

Test Plan:
- Nominal sequence:
  - Stimulus: rst, then start=1 with centre (80,60), r=20, colour=3'b011; fill model finishes after 19200 plots, circle model after 160 plots.
  - Required: fill_start high until fill_done, one low cycle, then circ_start. done=1 and error=0, with all 19200+160 plots forwarded 1 cycle late at the correct colours and clip_count=0.
- Clipping:
  - Stimulus: centre (5,5), r=20, with the circle model emitting x=241 (wrapped) and y=125.
  - Required: those pixels give vga_plot=0, clip_count equals the number of off-screen pixels, and on-screen pixels are forwarded.
- Timeout:
  - Stimulus: TIMEOUT=100 with circ_done never asserting.
  - Required: after 100 CIRC cycles circ_start drops, done=1 and error=1. Also check that done and timeout on the same cycle gives error=0.
- Handshake and idle:
  - Stimulus: keep start=1 after done, and change radius mid-CIRC.
  - Required: the block stays in DONE with no restart and circ_radius stays unchanged. start=0 returns to IDLE and done=0 next cycle.
- Reset mid-operation:
  - Stimulus: assert rst during FILL, 500 cycles in.
  - Required: the next cycle has fill_start=0, vga_plot=0, done=0, clip_count=0 and state IDLE. A subsequent start runs the full sequence.
- CLEAR_EN=0:
  - Stimulus: start.
  - Required: fill_start never asserts, circ_start rises the cycle after start is sampled, and fill_plot pulses are ignored.
